// File: rtl/hps_reset_pkg.sv
// Shared types and constants for the HPS reset-request sequencer.
// Optional statistics build: HPS_RESET_SEQ_STATS_EN.
package hps_reset_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ASSERT,
    HOLDOFF
  } state_t;

  localparam int COLD  = 0;
  localparam int WARM  = 1;
  localparam int DEBUG = 2;

  localparam logic [1:0] LT_NONE  = 2'd0;
  localparam logic [1:0] LT_COLD  = 2'd1;
  localparam logic [1:0] LT_WARM  = 2'd2;
  localparam logic [1:0] LT_DEBUG = 2'd3;

  localparam int STAT_W = 8;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hps_reset_sequencer_sat_counter.sv
// Saturating up-counter with increment enable.
// Used for the optional statistics (HPS_RESET_SEQ_STATS_EN).
module sat_counter #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/hps_reset_sequencer.sv
// Turns cold/warm/debug request levels into serialised, prioritised
// active-low HPS reset pulses. Stats ports: HPS_RESET_SEQ_STATS_EN.
module hps_reset_sequencer
  import hps_reset_pkg::*;
#(
  parameter int COLD_CYCLES    = 6,
  parameter int WARM_CYCLES    = 2,
  parameter int DEBUG_CYCLES   = 32,
  parameter int HOLDOFF_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  req_in,
  output logic        cold_req_n,
  output logic        warm_req_n,
  output logic        debug_req_n,
  output logic        busy,
  output logic [1:0]  last_type
`ifdef HPS_RESET_SEQ_STATS_EN
  ,
  output logic [STAT_W-1:0] cold_cnt,
  output logic [STAT_W-1:0] warm_cnt,
  output logic [STAT_W-1:0] debug_cnt,
  output logic [STAT_W-1:0] drop_cnt
`endif
);

  localparam int MAXP = max2(max2(COLD_CYCLES, WARM_CYCLES),
                             max2(DEBUG_CYCLES, HOLDOFF_CYCLES));
  localparam int CW = $clog2(MAXP) + 1;

  localparam logic [CW-1:0] C_COLD  = CW'(COLD_CYCLES - 1);
  localparam logic [CW-1:0] C_WARM  = CW'(WARM_CYCLES - 1);
  localparam logic [CW-1:0] C_DEBUG = CW'(DEBUG_CYCLES - 1);
  localparam logic [CW-1:0] C_HOLD  =
    (HOLDOFF_CYCLES == 0) ? '0 : CW'(HOLDOFF_CYCLES - 1);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_req_d;
  logic [2:0]    r_pend;
  logic [1:0]    r_last;
  logic          r_busy;
  logic          r_cold_n;
  logic          r_warm_n;
  logic          r_debug_n;

  state_t        w_state_n;
  logic [CW-1:0] w_cnt_n;
  logic [2:0]    w_pend_n;
  logic [1:0]    w_last_n;
  logic [2:0]    w_edge;
  logic [2:0]    w_pick;
  logic [2:0]    w_clr;
  logic [2:0]    w_launch;
  logic          w_abort;

  assign w_edge = req_in & ~r_req_d;
  // Lowest set bit is the highest-priority pending request.
  assign w_pick = r_pend & (~r_pend + 3'd1);

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_last_n  = r_last;
    w_clr     = '0;
    w_launch  = '0;
    w_abort   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (|r_pend) begin
          w_state_n = ASSERT;
          w_clr     = w_pick;
          w_launch  = w_pick;
          unique case (1'b1)
            w_pick[COLD]: begin
              w_cnt_n  = C_COLD;
              w_last_n = LT_COLD;
            end
            w_pick[WARM]: begin
              w_cnt_n  = C_WARM;
              w_last_n = LT_WARM;
            end
            default: begin
              w_cnt_n  = C_DEBUG;
              w_last_n = LT_DEBUG;
            end
          endcase
        end
      end
      ASSERT: begin
        if (w_edge[COLD] && (r_last != LT_COLD)) begin
          // Cold aborts warm/debug; the aborted request is dropped.
          w_abort        = 1'b1;
          w_launch[COLD] = 1'b1;
          w_cnt_n        = C_COLD;
          w_last_n       = LT_COLD;
        end else if (r_cnt == '0) begin
          if (HOLDOFF_CYCLES == 0) begin
            w_state_n = IDLE;
          end else begin
            w_state_n = HOLDOFF;
            w_cnt_n   = C_HOLD;
          end
        end else begin
          w_cnt_n = r_cnt - 1'b1;
        end
      end
      HOLDOFF: begin
        if (r_cnt == '0) begin
          w_state_n = IDLE;
        end else begin
          w_cnt_n = r_cnt - 1'b1;
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  assign w_pend_n = (r_pend & ~w_clr) |
                    (w_edge & ~{1'b0, 1'b0, w_abort});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_req_d   <= 3'b111;
      r_pend    <= '0;
      r_last    <= LT_NONE;
      r_busy    <= 1'b0;
      r_cold_n  <= 1'b1;
      r_warm_n  <= 1'b1;
      r_debug_n <= 1'b1;
    end else begin
      r_state   <= w_state_n;
      r_cnt     <= w_cnt_n;
      r_req_d   <= req_in;
      r_pend    <= w_pend_n;
      r_last    <= w_last_n;
      r_busy    <= (w_state_n != IDLE);
      r_cold_n  <= !((w_state_n == ASSERT) && (w_last_n == LT_COLD));
      r_warm_n  <= !((w_state_n == ASSERT) && (w_last_n == LT_WARM));
      r_debug_n <= !((w_state_n == ASSERT) && (w_last_n == LT_DEBUG));
    end
  end

  assign cold_req_n  = r_cold_n;
  assign warm_req_n  = r_warm_n;
  assign debug_req_n = r_debug_n;
  assign busy        = r_busy;
  assign last_type   = r_last;

`ifdef HPS_RESET_SEQ_STATS_EN
  logic [2:0] w_dup;
  logic       w_drop;

  // A new edge on a still-pending bit merges into it.
  assign w_dup  = w_edge & r_pend & ~w_clr;
  assign w_drop = w_abort | (|w_dup);

  sat_counter #(.W(STAT_W)) u_cold_cnt (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_inc   (w_launch[COLD]),
    .o_count (cold_cnt)
  );

  sat_counter #(.W(STAT_W)) u_warm_cnt (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_inc   (w_launch[WARM]),
    .o_count (warm_cnt)
  );

  sat_counter #(.W(STAT_W)) u_debug_cnt (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_inc   (w_launch[DEBUG]),
    .o_count (debug_cnt)
  );

  sat_counter #(.W(STAT_W)) u_drop_cnt (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_inc   (w_drop),
    .o_count (drop_cnt)
  );
`else
  logic w_unused;
  assign w_unused = ^w_launch;
`endif

endmodule
